// File: rtl/asyn_fifo_read_serializer_if.sv
// Purpose: bundles the FIFO read port and the lane stream of the read serializer.
// Latency: none, this is a wiring bundle only.
// Backpressure: out_ready from the sink; read_empty from the FIFO.
interface asyn_fifo_read_serializer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8
);
  logic [DATA_WIDTH-1:0] read_data;
  logic                  read_empty;
  logic                  read_ena;
  logic [OUT_WIDTH-1:0]  out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  // Serializer side.
  modport master (
    input  read_data, read_empty, out_ready,
    output read_ena, out_data, out_valid, out_last
  );

  // FIFO and downstream sink side.
  modport slave (
    output read_data, read_empty, out_ready,
    input  read_ena, out_data, out_valid, out_last
  );
endinterface

// File: rtl/asyn_fifo_read_serializer.sv
// Purpose: pops FIFO words and streams them out as OUT_WIDTH lanes, least-significant lane first.
// Latency: first lane one cycle after read_empty falls; then one lane per cycle with no bubble between words.
// Backpressure: out_ready low freezes the current lane; the FIFO is popped only on final-lane fire or when idle.
module asyn_fifo_read_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                     read_clk,
  input  logic                     read_rst,
  asyn_fifo_read_serializer_if.master bus,
  output logic [CNT_WIDTH-1:0]     word_cnt
);

  localparam int RATIO  = DATA_WIDTH / OUT_WIDTH;
  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  // ST_FULL means the holding register carries a word with lanes still to send.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [RATIO-1:0][OUT_WIDTH-1:0] r_hold_data;
  logic [RATIO-1:0][OUT_WIDTH-1:0] w_hold_data_nxt;
  logic [LANE_W-1:0]              r_lane;
  logic [LANE_W-1:0]              w_lane_nxt;
  logic [CNT_WIDTH-1:0]           r_word_cnt;
  logic [CNT_WIDTH-1:0]           w_word_cnt_nxt;

  logic w_hold_valid;
  logic w_last;
  logic w_fire;
  logic w_load;

  assign w_hold_valid = (r_state == ST_FULL);
  assign w_last       = w_hold_valid && (r_lane == LANE_W'(RATIO - 1));
  assign w_fire       = w_hold_valid && bus.out_ready;
  // Refill only when idle or when the final lane leaves this cycle, so a
  // partially sent word is never overwritten. read_data is not in this cone.
  assign w_load       = !read_rst && !bus.read_empty && (!w_hold_valid || (w_fire && w_last));

  assign bus.read_ena  = w_load;
  assign bus.out_valid = w_hold_valid;
  assign bus.out_data  = r_hold_data[r_lane];
  assign bus.out_last  = w_last;
  assign word_cnt      = r_word_cnt;

  // Next-state: load beats last-lane retire, which beats a plain lane advance.
  always_comb begin
    w_state_nxt     = r_state;
    w_hold_data_nxt = r_hold_data;
    w_lane_nxt      = r_lane;
    w_word_cnt_nxt  = r_word_cnt;
    if (w_load) begin
      w_state_nxt     = ST_FULL;
      w_hold_data_nxt = bus.read_data;
      w_lane_nxt      = '0;
      w_word_cnt_nxt  = r_word_cnt + CNT_WIDTH'(1);
    end else if (w_fire && w_last) begin
      w_state_nxt = ST_EMPTY;
      w_lane_nxt  = '0;
    end else if (w_fire) begin
      w_lane_nxt = r_lane + LANE_W'(1);
    end
  end

  // State registers with synchronous reset; reset discards any word in flight.
  always_ff @(posedge read_clk) begin
    if (read_rst) begin
      r_state     <= ST_EMPTY;
      r_hold_data <= '0;
      r_lane      <= '0;
      r_word_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold_data <= w_hold_data_nxt;
      r_lane      <= w_lane_nxt;
      r_word_cnt  <= w_word_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_asyn_fifo_read_serializer.sv
// Purpose: directed self-checking bench for the FIFO read serializer.
// Latency: FWFT FIFO model with a registered empty flag feeds the DUT.
// Backpressure: out_ready driven directly and randomly in the long stream test.
module tb_asyn_fifo_read_serializer;
  localparam int DW = 32;
  localparam int OW = 8;
  localparam int CW = 4;

  logic          clk        = 1'b0;
  logic          read_rst   = 1'b1;
  logic          out_ready  = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_head  = '0;
  logic [CW-1:0] word_cnt;

  logic [DW-1:0] fifo[$];
  logic [OW-1:0] rx[$];
  logic [DW-1:0] t3_words[$];
  bit            mon_on     = 1'b0;
  bit            prev_stall = 1'b0;
  logic [OW-1:0] prev_dat   = '0;
  int            n_chk      = 0;
  int            n_fail     = 0;

  always #5 clk = ~clk;

  asyn_fifo_read_serializer_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) bus ();

  assign bus.read_data  = fifo_head;
  assign bus.read_empty = fifo_empty;
  assign bus.out_ready  = out_ready;

  asyn_fifo_read_serializer #(
    .DATA_WIDTH(DW),
    .OUT_WIDTH (OW),
    .CNT_WIDTH (CW)
  ) dut (
    .read_clk(clk),
    .read_rst(read_rst),
    .bus     (bus.master),
    .word_cnt(word_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FWFT FIFO model: pop on read_ena, empty flag and head word registered.
  always @(posedge clk) begin
    if (bus.read_ena && fifo.size() != 0) fifo.delete(0);
    fifo_empty <= (fifo.size() == 0);
    fifo_head  <= (fifo.size() != 0) ? fifo[0] : '0;
  end

  // Stream monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.read_ena) chk("ena_while_empty", {31'b0, fifo_empty}, 32'd0);
    if (mon_on && prev_stall) begin
      chk("stall_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("stall_data", {24'b0, bus.out_data}, {24'b0, prev_dat});
    end
    prev_stall = bus.out_valid && !out_ready;
    prev_dat   = bus.out_data;
    if (bus.out_valid && out_ready) rx.push_back(bus.out_data);
  end

  // Push one word and wait for its last lane to leave (out_ready assumed high).
  task automatic send_word(input logic [DW-1:0] w);
    bit done;
    done = 1'b0;
    tick();
    fifo.push_back(w);
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_last && out_ready) done = 1'b1;
    end
    if (!done) chk("send_word_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] w3 [3];
    logic [DW-1:0] got;
    bit            seen;
    int            c;

    // Reset state.
    read_rst  = 1'b1;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_last", {31'b0, bus.out_last}, 32'd0);
    chk("rst_data", {24'b0, bus.out_data}, 32'd0);
    chk("rst_ena", {31'b0, bus.read_ena}, 32'd0);
    chk("rst_cnt", {28'b0, word_cnt}, 32'd0);
    tick();
    read_rst  = 1'b0;
    out_ready = 1'b1;

    // Single word, LSB lane first.
    tick();
    fifo.push_back(32'h44332211);
    @(negedge clk);
    chk("t1_ena_pre", {31'b0, bus.read_ena}, 32'd0);
    @(negedge clk);
    chk("t1_ena", {31'b0, bus.read_ena}, 32'd1);
    chk("t1_valid_pre", {31'b0, bus.out_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("t1_data", {24'b0, bus.out_data}, 32'h11 * (i + 1));
      chk("t1_last", {31'b0, bus.out_last}, (i == 3) ? 32'd1 : 32'd0);
      chk("t1_ena_lane", {31'b0, bus.read_ena}, 32'd0);
    end
    @(negedge clk);
    chk("t1_valid_post", {31'b0, bus.out_valid}, 32'd0);
    chk("t1_cnt", {28'b0, word_cnt}, 32'd1);

    // Three words back to back: 12 valid cycles, read_ena every 4th.
    w3[0] = 32'h03020100;
    w3[1] = 32'h07060504;
    w3[2] = 32'h0B0A0908;
    tick();
    for (int i = 0; i < 3; i++) fifo.push_back(w3[i]);
    @(negedge clk);
    for (c = 0; c < 14; c++) begin
      @(negedge clk);
      chk("t2_valid", {31'b0, bus.out_valid}, (c >= 1 && c <= 12) ? 32'd1 : 32'd0);
      chk("t2_ena", {31'b0, bus.read_ena}, ((c % 4) == 0 && c < 12) ? 32'd1 : 32'd0);
      if (c >= 1 && c <= 12)
        chk("t2_data", {24'b0, bus.out_data}, 32'(c - 1));
    end
    chk("t2_cnt", {28'b0, word_cnt}, 32'd4);

    // Idle FIFO for 20 cycles, then a late word.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t4_idle_ena", {31'b0, bus.read_ena}, 32'd0);
      chk("t4_idle_valid", {31'b0, bus.out_valid}, 32'd0);
    end
    tick();
    fifo.push_back(32'hA5B6C7D8);
    seen = 1'b0;
    for (int k = 0; k < 5 && !seen; k++) begin
      @(negedge clk);
      if (!fifo_empty) seen = 1'b1;
    end
    chk("t4_empty_fell", {31'b0, seen}, 32'd1);
    chk("t4_ena", {31'b0, bus.read_ena}, 32'd1);
    @(negedge clk);
    chk("t4_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("t4_lane0", {24'b0, bus.out_data}, 32'hD8);
    repeat (4) @(negedge clk);
    chk("t4_cnt", {28'b0, word_cnt}, 32'd5);

    // Reset after lane 1 of 0xDDCCBBAA.
    tick();
    rx.delete();
    fifo.push_back(32'hDDCCBBAA);
    fifo.push_back(32'h55667788);
    repeat (4) @(negedge clk);
    chk("t5_lane1", {24'b0, bus.out_data}, 32'hBB);
    tick();
    read_rst  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("t5_rst_fifo_nonempty", {31'b0, fifo_empty}, 32'd0);
    chk("t5_rst_ena", {31'b0, bus.read_ena}, 32'd0);
    tick();
    read_rst  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t5_valid_after_rst", {31'b0, bus.out_valid}, 32'd0);
    chk("t5_cnt_after_rst", {28'b0, word_cnt}, 32'd0);
    chk("t5_ena_after_rst", {31'b0, bus.read_ena}, 32'd1);
    @(negedge clk);
    chk("t5_next_lane0", {24'b0, bus.out_data}, 32'h88);
    repeat (4) @(negedge clk);
    chk("t5_rx_count", 32'(rx.size()), 32'd6);
    if (rx.size() == 6) begin
      chk("t5_rx", {rx[0], rx[1], rx[2], rx[3]}, 32'hAABB8877);
      chk("t5_rx_tail", {16'b0, rx[4], rx[5]}, 32'h00006655);
    end
    chk("t5_cnt", {28'b0, word_cnt}, 32'd1);

    // 200 random words with random backpressure.
    tick();
    rx.delete();
    mon_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          logic [DW-1:0] w;
          w = $urandom;
          t3_words.push_back(w);
          fifo.push_back(w);
          repeat ($urandom_range(0, 6)) tick();
          tick();
        end
      end
      begin
        for (int k = 0; k < 20000 && rx.size() < 800; k++) begin
          tick();
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    mon_on    = 1'b0;
    @(negedge clk);
    chk("t3_rx_count", 32'(rx.size()), 32'd800);
    for (int i = 0; i < 200; i++) begin
      if (rx.size() >= 4 * i + 4) begin
        got = {rx[4*i+3], rx[4*i+2], rx[4*i+1], rx[4*i]};
        chk("t3_word", got, t3_words[i]);
      end
    end
    chk("t3_cnt", {28'b0, word_cnt}, 32'd9);

    // Counter wrap with a 4-bit counter.
    tick();
    read_rst = 1'b1;
    tick();
    read_rst = 1'b0;
    for (int n = 1; n <= 17; n++) begin
      send_word(32'h01010101 * n);
      if (n == 15) chk("t6_cnt15", {28'b0, word_cnt}, 32'hF);
      if (n == 16) chk("t6_cnt16", {28'b0, word_cnt}, 32'h0);
      if (n == 17) chk("t6_cnt17", {28'b0, word_cnt}, 32'h1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
